// File: rtl/add128_seq.sv
// 128-bit adder that reuses an external 10-bit adder over 13 slice cycles.
// Optional subtraction (A-B) is enabled by defining ADD128_SUB_EN.
module add128_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] a,
   input  logic [127:0] b,
   output logic [9:0]   sa,
   output logic [9:0]   sb,
   input  logic [10:0]  sf,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [128:0] sum
`ifdef ADD128_SUB_EN
   ,
   input  logic         sub
`endif
);

   // state | meaning
   // IDLE  | waiting for an operand pair, in_ready high
   // RUN   | one 10-bit slice per cycle, idx 0..12
   // DONE  | result held with out_valid high until out_ready
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] LAST_IDX = 4'd12;

   logic [1:0]   state;
   logic [3:0]   idx;
   logic [127:0] a_reg;
   logic [127:0] b_reg;
   logic         sub_reg;
   logic         sub_in;
   logic         carry;
   logic [128:0] sum_r;
   logic [9:0]   a_slice;
   logic [9:0]   b_slice;
   logic [10:0]  t;

`ifdef ADD128_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   // Gate with rst so the block never advertises readiness during reset.
   assign in_ready = (state == IDLE) && !rst;
   assign sum      = sum_r;

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < 12; i++) begin
         if (idx == 4'(i)) begin
            a_slice = a_reg[10*i +: 10];
            b_slice = sub_reg ? ~b_reg[10*i +: 10] : b_reg[10*i +: 10];
         end
      end
      // Top slice is only 8 bits wide; inversion happens before zero-extension.
      if (idx == LAST_IDX) begin
         a_slice = {2'b00, a_reg[127:120]};
         b_slice = {2'b00, (sub_reg ? ~b_reg[127:120] : b_reg[127:120])};
      end
   end

   assign sa = (state == RUN) ? a_slice : 10'd0;
   assign sb = (state == RUN) ? b_slice : 10'd0;
   assign t  = sf + {10'd0, carry};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= 4'd0;
         carry     <= 1'b0;
         sum_r     <= '0;
         out_valid <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg   <= a;
                  b_reg   <= b;
                  sub_reg <= sub_in;
                  carry   <= sub_in;
                  idx     <= 4'd0;
                  state   <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < 12; i++) begin
                  if (idx == 4'(i)) begin
                     sum_r[10*i +: 10] <= t[9:0];
                  end
               end
               if (idx == LAST_IDX) begin
                  sum_r[127:120] <= t[7:0];
                  sum_r[128]     <= t[8];
                  idx            <= 4'd0;
                  out_valid      <= 1'b1;
                  state          <= DONE;
               end else begin
                  carry <= t[10];
                  idx   <= idx + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add128_seq.sv
// Self-checking bench for add128_seq; models the external 10-bit adder and
// checks results against plain 129-bit arithmetic.
module tb_add128_seq;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] a;
   logic [127:0] b;
   logic [9:0]   sa;
   logic [9:0]   sb;
   logic [10:0]  sf;
   logic         out_valid;
   logic         out_ready;
   logic [128:0] sum;
`ifdef ADD128_SUB_EN
   logic         sub_i;
`endif

   int checks   = 0;
   int failures = 0;

   logic [9:0] sa_log [0:12];
   logic [9:0] sb_log [0:12];

   add128_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sa        (sa),
      .sb        (sb),
      .sf        (sf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
`ifdef ADD128_SUB_EN
      ,
      .sub       (sub_i)
`endif
   );

   // External 10-bit adder.
   assign sf = {1'b0, sa} + {1'b0, sb};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [128:0] ref_sum(logic [127:0] x, logic [127:0] y, logic s);
      if (s) return {1'b0, x} + {1'b0, ~y} + 129'd1;
      return {1'b0, x} + {1'b0, y};
   endfunction

   function automatic logic [9:0] ref_sa(logic [127:0] x, int i);
      logic [127:0] sh;
      sh = x >> (10 * i);
      return (i == 12) ? {2'b00, sh[7:0]} : sh[9:0];
   endfunction

   function automatic logic [9:0] ref_sb(logic [127:0] y, logic s, int i);
      logic [127:0] sh;
      sh = y >> (10 * i);
      if (s) sh = ~sh;
      return (i == 12) ? {2'b00, sh[7:0]} : sh[9:0];
   endfunction

   task automatic start_op(input logic [127:0] x, input logic [127:0] y, input logic s);
      @(negedge clk);
      a = x;
      b = y;
`ifdef ADD128_SUB_EN
      sub_i = s;
`endif
      in_valid = 1'b1;
      for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called at the negedge after the accept edge; scrambles inputs meanwhile.
   task automatic wait_done(output int lat);
      lat = -1;
      sa_log[0] = sa;
      sb_log[0] = sb;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         a        = rnd128();
         b        = rnd128();
         in_valid = 1'($urandom() % 2);
         if (out_valid) begin
            lat = n;
            break;
         end
         if (n <= 12) begin
            sa_log[n] = sa;
            sb_log[n] = sb;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || sum !== 129'd0) begin
         failures++;
         $display("FAIL reset_outputs: out_valid=%b sum=%h want 0/0", out_valid, sum);
      end
      checks++;
      if (sa !== 10'd0 || sb !== 10'd0) begin
         failures++;
         $display("FAIL reset_slices: sa=%h sb=%h want 0/0", sa, sb);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_zero();
      int lat;
      start_op(128'd0, 128'd0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 13) begin
         failures++;
         $display("FAIL zero_latency: got %0d want 13", lat);
      end
      checks++;
      if (sum !== 129'd0) begin
         failures++;
         $display("FAIL zero_sum: got %h want 0", sum);
      end
      finish_op();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL zero_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_chunk_carry();
      int lat;
      start_op(128'h3FF, 128'h1, 1'b0);
      wait_done(lat);
      checks++;
      if (sa_log[0] !== 10'h3FF || sb_log[0] !== 10'h001) begin
         failures++;
         $display("FAIL chunk_slice0: sa=%h sb=%h want 3ff/001", sa_log[0], sb_log[0]);
      end
      checks++;
      if (lat !== 13 || sum !== 129'h400) begin
         failures++;
         $display("FAIL chunk_sum: lat=%0d sum=%h want 13/400", lat, sum);
      end
      finish_op();
   endtask

   task automatic test_all_ones();
      int lat;
      logic [127:0] ones;
      ones = '1;
      start_op(ones, 128'd1, 1'b0);
      wait_done(lat);
      checks++;
      if (sa_log[12] !== 10'h0FF || sb_log[12] !== 10'h000) begin
         failures++;
         $display("FAIL ones_top_slice: sa=%h sb=%h want 0ff/000", sa_log[12], sb_log[12]);
      end
      checks++;
      if (lat !== 13 || sum[128] !== 1'b1 || sum[127:0] !== 128'd0) begin
         failures++;
         $display("FAIL ones_sum: lat=%0d sum=%h want 13/1_0", lat, sum);
      end
      finish_op();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [127:0] x1, y1, x2, y2;
      logic [128:0] e1;
      x1 = rnd128(); y1 = rnd128(); x2 = rnd128(); y2 = rnd128();
      e1 = ref_sum(x1, y1, 1'b0);
      start_op(x1, y1, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 13 || sum !== e1) begin
         failures++;
         $display("FAIL bp_first: lat=%0d sum=%h want 13/%h", lat, sum, e1);
      end
      for (int c = 0; c < 5; c++) begin
         a = rnd128();
         b = rnd128();
         in_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || sum !== e1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h want 1/0/%h",
                     c, out_valid, in_ready, sum, e1);
         end
      end
      a = x2;
      b = y2;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_second_accept: in_ready=%b want 0", in_ready);
      end
      wait_done(lat);
      checks++;
      if (lat !== 13 || sum !== ref_sum(x2, y2, 1'b0)) begin
         failures++;
         $display("FAIL bp_second: lat=%0d sum=%h want 13/%h", lat, sum, ref_sum(x2, y2, 1'b0));
      end
      finish_op();
   endtask

   task automatic test_reset_midway();
      int lat;
      logic [127:0] x, y;
      x = rnd128(); y = rnd128();
      start_op(x, y, 1'b0);
      repeat (6) begin
         @(negedge clk);
         a = rnd128();
         b = rnd128();
      end
      checks++;
      if (sa !== ref_sa(x, 6)) begin
         failures++;
         $display("FAIL mid_slice6: sa=%h want %h", sa, ref_sa(x, 6));
      end
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 129'd0 || in_ready !== 1'b0 || sa !== 10'd0 || sb !== 10'd0) begin
         failures++;
         $display("FAIL mid_reset: out_valid=%b sum=%h in_ready=%b sa=%h sb=%h want 0/0/0/0/0",
                  out_valid, sum, in_ready, sa, sb);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      start_op(128'd1, 128'd2, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 13 || sum !== 129'd3) begin
         failures++;
         $display("FAIL mid_next_op: lat=%0d sum=%h want 13/3", lat, sum);
      end
      finish_op();
   endtask

   task automatic test_random(input logic s, input int count);
      int lat;
      int bad;
      logic [127:0] x, y;
      logic [128:0] e;
      for (int k = 0; k < count; k++) begin
         x = rnd128();
         y = rnd128();
         case (k % 4)
            1: x[127:120] = 8'hFF;
            2: y = ~x;
            default: ;
         endcase
         e = ref_sum(x, y, s);
         start_op(x, y, s);
         wait_done(lat);
         checks++;
         if (lat !== 13 || sum !== e) begin
            failures++;
            $display("FAIL rand%0d_sub%0b: lat=%0d sum=%h want 13/%h", k, s, lat, sum, e);
         end
         bad = 0;
         for (int i = 0; i <= 12; i++) begin
            if (sa_log[i] !== ref_sa(x, i) || sb_log[i] !== ref_sb(y, s, i)) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL rand%0d_slices: %0d slice mismatches of 13, want 0", k, bad);
         end
         finish_op();
      end
   endtask

`ifdef ADD128_SUB_EN
   task automatic test_subtract();
      int lat;
      start_op(128'd5, 128'd7, 1'b1);
      wait_done(lat);
      checks++;
      if (lat !== 13 || sum[128] !== 1'b0 || sum[127:0] !== (128'd0 - 128'd2)) begin
         failures++;
         $display("FAIL sub_5_7: lat=%0d sum=%h want 13/0_fff..fe", lat, sum);
      end
      finish_op();
      start_op(128'd7, 128'd5, 1'b1);
      wait_done(lat);
      checks++;
      if (lat !== 13 || sum[128] !== 1'b1 || sum[127:0] !== 128'd2) begin
         failures++;
         $display("FAIL sub_7_5: lat=%0d sum=%h want 13/1_2", lat, sum);
      end
      finish_op();
      test_random(1'b1, 8);
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
`ifdef ADD128_SUB_EN
      sub_i     = 1'b0;
`endif
      test_reset();
      test_zero();
      test_chunk_carry();
      test_all_ones();
      test_backpressure();
      test_reset_midway();
      test_random(1'b0, 16);
`ifdef ADD128_SUB_EN
      test_subtract();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
